sd_cmd_seq: RTL and testbench
=============================

// Module: sd_cmd_seq
// PURPOSE
// SD-card command sequencer that sits directly upstream of the SPI byte engine (spi).
// - Frames one SD command (6 bytes), polls for the R1 response and, on request, reads one data block.
// - Streams the block bytes to a sector buffer.
// - Used by the floppy/SD controller in place of byte-by-byte firmware polling.
// PARAMETERS
// NCR_MAX    8      max 0xFF poll bytes waiting for R1 (bit7==0) before timeout
// TOKEN_MAX  4096   max 0xFF poll bytes waiting for data token before timeout
// BLK_LEN    512    data block length in bytes (1..1024)
// PORTS
// clk        in   1   system clock
// reset_n    in   1   asynchronous active-low reset
// spi_ce     in   1   same clock enable that feeds spi.ce
// start      in   1   1-cycle pulse: begin transaction (ignored while busy)
// cmd_idx    in   6   SD command index
// cmd_arg    in   32  command argument, sent MSB first
// cmd_crc    in   7   CRC7 for the command frame
// rd_block   in   1   1: read a data block after R1==0x00
// busy       out  1   transaction in progress
// done       out  1   1-cycle pulse at end of transaction
// r1         out  8   last R1 byte received
// err_tmo    out  1   sticky until next start: NCR or token timeout
// err_tok    out  1   sticky until next start: data error token received
// cs_n       out  1   SD chip select, low while busy
// spi_di     out  8   byte to the SPI engine
// spi_wr     out  1   write request to the SPI engine
// spi_do     in   8   byte received by the SPI engine
// spi_dsr    in   1   SPI engine byte-done flag
// dat_o      out  8   block data byte
// dat_addr   out  10  block byte index, 0..BLK_LEN-1
// dat_we     out  1   1-cycle strobe, dat_o/dat_addr valid
// BEHAVIOUR
// Reset values:
// - busy=0, done=0, r1=8'hFF, err_tmo=0, err_tok=0, cs_n=1, spi_di=8'hFF, spi_wr=0.
// - dat_o=0, dat_addr=0, dat_we=0, state=IDLE.
// Reset mid-transaction returns to these values at once; no partial done pulse.
// Byte handshake (XFER, used for every byte):
// - Drive spi_di and set spi_wr=1.
// - Hold spi_wr until a cycle with spi_ce=1 and spi_wr=1 (accept edge); clear spi_wr on the next edge.
// - From the cycle after accept, wait for spi_dsr==1. The engine clears dsr on accept.
// - On spi_dsr==1, capture spi_do; the next byte's spi_wr may assert on the following cycle.
// States:
// - IDLE: start -> latch inputs, clear errors, busy=1, cs_n=0 -> PRE.
// - PRE: XFER 8'hFF (Ncs gap) -> CMD.
// - CMD: XFER {2'b01,cmd_idx}, arg[31:24], [23:16], [15:8], [7:0], {cmd_crc,1'b1}. 3-bit counter; after byte 6 -> NCR, poll counter=0.
// - NCR: XFER 8'hFF.
//   - spi_do[7]==0 -> r1<=spi_do; (rd_block && spi_do==0) ? TOKEN : DONE.
//   - else poll++; poll==NCR_MAX -> err_tmo=1, DONE.
//   - R1 received on poll N (1-based) = N poll bytes.
// - TOKEN: XFER 8'hFF, 16-bit poll counter.
//   - 8'hFE -> DATA, addr=0.
//   - spi_do[7:4]==0 -> err_tok=1, dat_o<=spi_do, DONE.
//   - else poll++; poll==TOKEN_MAX -> err_tmo=1, DONE.
// - DATA: XFER 8'hFF.
//   - Each captured byte gives dat_o=spi_do and dat_we=1 for 1 cycle, with dat_addr = byte index.
//   - After index BLK_LEN-1 -> CRC.
// - CRC: XFER 8'hFF twice, bytes discarded (no dat_we) -> DONE.
// - DONE: cs_n=1, then XFER 8'hFF (8 trailing clocks with CS high), then done=1 one cycle, busy=0 -> IDLE.
// Rules:
// - start while busy: ignored, no state change.
// - start and done in the same cycle: cannot occur, because done is issued from DONE with busy still 1.
// - r1, err_* and the last dat_* values hold until the next start.
// - Counters never wrap: each bound is checked before increment.
// TESTING
// - CMD0 arg=0 crc=7'h4A, rd_block=0; model R1=0x01 on poll 2 -> spi bytes FF,40,00,00,00,00,95,FF,FF,FF(trail); r1=01; done once; no dat_we.
// - Model returns FF forever, NCR_MAX=8 -> exactly 8 NCR polls; err_tmo=1; r1=FF; cs_n high before trailing byte; done.
// - CMD17 arg=0x00000800, R1=00, token FE after 3 FF polls, data i&0xFF -> 512 dat_we, addr 0..511 with dat_o=addr[7:0]; 2 CRC bytes; err_*=0.
// - CMD17, token 0x05 -> err_tok=1, dat_o=05, no dat_we, done; next start clears err_tok.
// - spi_ce high 1 cycle in 4 -> spi_wr held until the ce cycle, 1 accept per byte; start pulsed mid-transfer ignored.
// - reset_n low during DATA (addr=100) -> all outputs at reset values same cycle; new CMD0 after release completes normally.

Source files
------------

// File: rtl/sd_cmd_seq.sv
// SD-card command sequencer in front of the SPI byte engine: frames one command,
// polls for R1, optionally reads one data block and streams it to a sector buffer.
module sd_cmd_seq #(
    parameter int NCR_MAX   = 8,
    parameter int TOKEN_MAX = 4096,
    parameter int BLK_LEN   = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_ce,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        rd_block,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        err_tmo,
    output logic        err_tok,
    output logic        cs_n,
    output logic [7:0]  spi_di,
    output logic        spi_wr,
    input  logic [7:0]  spi_do,
    input  logic        spi_dsr,
    output logic [7:0]  dat_o,
    output logic [9:0]  dat_addr,
    output logic        dat_we
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_CMD, S_NCR, S_TOKEN, S_DATA, S_CRC, S_DONE, S_FIN
    } state_t;

    localparam logic [15:0] NCR_LAST = 16'(NCR_MAX - 1);
    localparam logic [15:0] TOK_LAST = 16'(TOKEN_MAX - 1);
    localparam logic [15:0] BLK_LAST = 16'(BLK_LEN - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        pend;
    logic        rd_l;
    logic [5:0]  idx_l;
    logic [31:0] arg_l;
    logic [6:0]  crc_l;

    logic        byte_ok, xfer_state, issue;
    logic [7:0]  tx_byte;
    logic        start_go, cnt_clr, cnt_inc, r1_we, tmo_set, tok_set, dat_cap;

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FIN);
    assign cs_n       = (state == S_IDLE) || (state == S_DONE) || (state == S_FIN);
    assign xfer_state = busy && (state != S_FIN);
    assign byte_ok    = pend && spi_dsr;
    assign issue      = xfer_state && !spi_wr && !pend;

    always_comb begin
        tx_byte = 8'hFF;
        if (state == S_CMD) begin
            case (cnt[2:0])
                3'd0:    tx_byte = {2'b01, idx_l};
                3'd1:    tx_byte = arg_l[31:24];
                3'd2:    tx_byte = arg_l[23:16];
                3'd3:    tx_byte = arg_l[15:8];
                3'd4:    tx_byte = arg_l[7:0];
                3'd5:    tx_byte = {crc_l, 1'b1};
                default: tx_byte = 8'hFF;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        r1_we     = 1'b0;
        tmo_set   = 1'b0;
        tok_set   = 1'b0;
        dat_cap   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_go  = 1'b1;
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                if (byte_ok) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (byte_ok) begin
                    if (cnt[2:0] == 3'd5) begin
                        cnt_clr   = 1'b1;
                        state_nxt = S_NCR;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_NCR: begin
                if (byte_ok) begin
                    if (!spi_do[7]) begin
                        r1_we     = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = (rd_l && spi_do == 8'h00) ? S_TOKEN : S_DONE;
                    end else if (cnt == NCR_LAST) begin
                        tmo_set   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_TOKEN: begin
                if (byte_ok) begin
                    if (spi_do == 8'hFE) begin
                        cnt_clr   = 1'b1;
                        state_nxt = S_DATA;
                    end else if (spi_do[7:4] == 4'h0) begin
                        tok_set   = 1'b1;
                        state_nxt = S_DONE;
                    end else if (cnt == TOK_LAST) begin
                        tmo_set   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (byte_ok) begin
                    dat_cap = 1'b1;
                    if (cnt == BLK_LAST) begin
                        cnt_clr   = 1'b1;
                        state_nxt = S_CRC;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_CRC: begin
                if (byte_ok) begin
                    if (cnt[0]) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (byte_ok) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            pend     <= 1'b0;
            rd_l     <= 1'b0;
            idx_l    <= '0;
            arg_l    <= '0;
            crc_l    <= '0;
            r1       <= 8'hFF;
            err_tmo  <= 1'b0;
            err_tok  <= 1'b0;
            spi_di   <= 8'hFF;
            spi_wr   <= 1'b0;
            dat_o    <= '0;
            dat_addr <= '0;
            dat_we   <= 1'b0;
        end else begin
            if (start_go) begin
                rd_l    <= rd_block;
                idx_l   <= cmd_idx;
                arg_l   <= cmd_arg;
                crc_l   <= cmd_crc;
                r1      <= 8'hFF;
                err_tmo <= 1'b0;
                err_tok <= 1'b0;
            end

            if (start_go || cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 16'd1;
            end

            // spi_wr stays up until the engine sees it together with spi_ce
            if (issue) begin
                spi_wr <= 1'b1;
                spi_di <= tx_byte;
            end else if (spi_wr && spi_ce) begin
                spi_wr <= 1'b0;
                pend   <= 1'b1;
            end else if (byte_ok) begin
                pend <= 1'b0;
            end

            if (r1_we)   r1      <= spi_do;
            if (tmo_set) err_tmo <= 1'b1;
            if (tok_set) err_tok <= 1'b1;

            dat_we <= dat_cap;
            if (dat_cap) begin
                dat_o    <= spi_do;
                dat_addr <= cnt[9:0];
            end else if (tok_set) begin
                dat_o <= spi_do;
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Bench for sd_cmd_seq: an SPI engine plus SD-card byte-stream model drives the DUT,
// and each transaction is scored against expectations derived from the card script.
module tb_sd_cmd_seq;

    localparam int NCR_MAX   = 8;
    localparam int TOKEN_MAX = 4096;
    localparam int BLK_LEN   = 512;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_ce = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cmd_idx = '0;
    logic [31:0] cmd_arg = '0;
    logic [6:0]  cmd_crc = '0;
    logic        rd_block = 1'b0;
    logic        busy, done, err_tmo, err_tok, cs_n, spi_wr, dat_we;
    logic [7:0]  r1, spi_di, dat_o;
    logic [9:0]  dat_addr;
    logic [7:0]  spi_do;
    logic        spi_dsr;

    sd_cmd_seq #(.NCR_MAX(NCR_MAX), .TOKEN_MAX(TOKEN_MAX), .BLK_LEN(BLK_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .spi_ce(spi_ce), .start(start),
        .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .rd_block(rd_block),
        .busy(busy), .done(done), .r1(r1), .err_tmo(err_tmo), .err_tok(err_tok),
        .cs_n(cs_n), .spi_di(spi_di), .spi_wr(spi_wr), .spi_do(spi_do), .spi_dsr(spi_dsr),
        .dat_o(dat_o), .dat_addr(dat_addr), .dat_we(dat_we)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] miso_q[$];
    logic [7:0] mosi_q[$];
    logic       cs_q[$];
    logic [9:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] exp_data [BLK_LEN];
    int         done_cnt = 0;
    int         done_nobusy = 0;
    int         wr_viol = 0;
    int         lat;
    logic       hold_chk, acc_chk;
    logic [7:0] m_dat_o = 8'h00;
    logic [9:0] m_dat_addr = 10'h000;

    int ce_mode = 0;
    int ce_ph = 0;
    always @(negedge clk) begin
        ce_ph = (ce_ph + 1) % 4;
        case (ce_mode)
            0:       spi_ce = 1'b1;
            1:       spi_ce = (ce_ph == 0);
            default: spi_ce = ($urandom_range(0, 1) == 1);
        endcase
    end

    // SPI engine: accept on ce&wr, 8 ce pulses later present the card byte with dsr
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_dsr  <= 1'b0;
            spi_do   <= 8'hFF;
            lat      <= 0;
            hold_chk <= 1'b0;
            acc_chk  <= 1'b0;
        end else begin
            if ((hold_chk && !spi_wr) || (acc_chk && spi_wr)) wr_viol <= wr_viol + 1;
            hold_chk <= spi_wr && !spi_ce;
            acc_chk  <= spi_wr && spi_ce;
            if (spi_ce && spi_wr) begin
                mosi_q.push_back(spi_di);
                cs_q.push_back(cs_n);
                spi_dsr <= 1'b0;
                lat     <= 8;
            end else if (lat > 0 && spi_ce) begin
                lat <= lat - 1;
                if (lat == 1) begin
                    spi_do  <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'hFF;
                    spi_dsr <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (dat_we) begin
                wa_q.push_back(dat_addr);
                wd_q.push_back(dat_o);
            end
            if (done) begin
                done_cnt++;
                if (!busy) done_nobusy++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, 64'({busy, done, r1, err_tmo, err_tok, cs_n, spi_di, spi_wr, dat_o, dat_addr, dat_we}),
            64'({1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 10'h000, 1'b0}));
    endtask

    task automatic run_txn(input string name, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc, input logic rd, input int r1_poll,
                           input logic [7:0] r1_val, input int tok_polls, input logic [7:0] tok_val,
                           input int dmode, input int cemode, input bit mid_start, input bit rst_mid);
        int npoll, nbytes, budget, bad, nw;
        bit tmo, tok, dat, tokerr, seen;
        logic [7:0]  exp_r1;
        logic [55:0] frame, got_frame;

        miso_q.delete(); mosi_q.delete(); cs_q.delete(); wa_q.delete(); wd_q.delete();
        done_cnt = 0; done_nobusy = 0; wr_viol = 0;
        ce_mode = cemode;

        for (int i = 0; i < 7; i++) miso_q.push_back(8'hFF);
        if (r1_poll >= 1 && r1_poll <= NCR_MAX) begin
            for (int i = 0; i < r1_poll - 1; i++) miso_q.push_back(8'hFF);
            miso_q.push_back(r1_val);
            npoll = r1_poll; exp_r1 = r1_val; tmo = 1'b0;
        end else begin
            npoll = NCR_MAX; exp_r1 = 8'hFF; tmo = 1'b1;
        end
        tok = !tmo && rd && (r1_val == 8'h00);
        dat = 1'b0; tokerr = 1'b0;
        nbytes = 7 + npoll + 1;
        if (tok) begin
            for (int i = 0; i < tok_polls; i++) miso_q.push_back(8'hFF);
            miso_q.push_back(tok_val);
            nbytes += tok_polls + 1;
            if (tok_val == 8'hFE) begin
                dat = 1'b1;
                for (int i = 0; i < BLK_LEN; i++) begin
                    exp_data[i] = (dmode == 0) ? 8'(i) : 8'($urandom);
                    miso_q.push_back(exp_data[i]);
                end
                miso_q.push_back(8'($urandom));
                miso_q.push_back(8'($urandom));
                nbytes += BLK_LEN + 2;
            end else begin
                tokerr = 1'b1;
            end
        end
        frame = {8'hFF, 2'b01, idx, arg, crc, 1'b1};

        @(negedge clk);
        cmd_idx = idx; cmd_arg = arg; cmd_crc = crc; rd_block = rd; start = 1'b1;
        budget = nbytes * ((cemode == 0) ? 16 : 60) + 50;
        seen = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (mid_start && cyc == 30) begin
                start = 1'b1; cmd_idx = ~idx; rd_block = ~rd;
            end else begin
                start = 1'b0; cmd_idx = idx; rd_block = rd;
            end
            if (rst_mid && dat_we && dat_addr == 10'd100) begin
                reset_n = 1'b0;
                #1;
                chk_reset_vals({name, "_async_reset_outputs"});
                chk({name, "_no_done_pulse"}, 64'(done_cnt), 64'd0);
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                m_dat_o = 8'h00; m_dat_addr = 10'h000;
                return;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!seen) begin
            chk({name, "_done_timeout"}, 64'd0, 64'd1);
            reset_n = 1'b0;
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            m_dat_o = 8'h00; m_dat_addr = 10'h000;
            return;
        end
        @(negedge clk);

        if (dat) begin
            m_dat_o = exp_data[BLK_LEN-1];
            m_dat_addr = 10'(BLK_LEN - 1);
        end else if (tokerr) begin
            m_dat_o = tok_val;
        end

        chk({name, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({name, "_done_with_busy"}, 64'(done_nobusy), 64'd0);
        chk({name, "_idle_after"}, 64'({busy, cs_n}), 64'({1'b0, 1'b1}));
        chk({name, "_r1"}, 64'(r1), 64'(exp_r1));
        chk({name, "_err_tmo"}, 64'(err_tmo), 64'(tmo));
        chk({name, "_err_tok"}, 64'(err_tok), 64'(tokerr));
        chk({name, "_spi_byte_count"}, 64'(mosi_q.size()), 64'(nbytes));
        got_frame = '0;
        if (mosi_q.size() >= 7)
            got_frame = {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3], mosi_q[4], mosi_q[5], mosi_q[6]};
        chk({name, "_cmd_frame"}, 64'(got_frame), 64'(frame));
        bad = 0;
        for (int i = 7; i < mosi_q.size(); i++) if (mosi_q[i] !== 8'hFF) bad++;
        chk({name, "_poll_bytes_ff"}, 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < cs_q.size(); i++) if (cs_q[i] !== (i == cs_q.size() - 1)) bad++;
        chk({name, "_cs_per_byte"}, 64'(bad), 64'd0);
        chk({name, "_wr_handshake"}, 64'(wr_viol), 64'd0);
        nw = dat ? BLK_LEN : 0;
        chk({name, "_dat_we_count"}, 64'(wa_q.size()), 64'(nw));
        bad = 0;
        for (int i = 0; i < wa_q.size() && i < nw; i++)
            if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_data[i]) bad++;
        chk({name, "_dat_contents"}, 64'(bad), 64'd0);
        chk({name, "_dat_hold"}, 64'({dat_o, dat_addr}), 64'({m_dat_o, m_dat_addr}));
    endtask

    initial begin
        logic [7:0] rv;
        bit rd;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_values");
        reset_n = 1'b1;
        @(negedge clk);

        run_txn("cmd0", 6'd0, 32'h0, 7'h4A, 1'b0, 2, 8'h01, 0, 8'h00, 0, 0, 1'b0, 1'b0);
        run_txn("ncr_timeout", 6'd8, 32'h000001AA, 7'h43, 1'b0, 0, 8'h00, 0, 8'h00, 0, 0, 1'b0, 1'b0);
        run_txn("cmd17_read", 6'd17, 32'h00000800, 7'h2A, 1'b1, 1, 8'h00, 3, 8'hFE, 0, 0, 1'b0, 1'b0);
        run_txn("cmd17_tok_err", 6'd17, 32'h00000800, 7'h2A, 1'b1, 1, 8'h00, 2, 8'h05, 0, 0, 1'b0, 1'b0);
        run_txn("cmd0_clears_err", 6'd0, 32'h0, 7'h4A, 1'b0, 1, 8'h01, 0, 8'h00, 0, 0, 1'b0, 1'b0);
        run_txn("ce_quarter_mid_start", 6'd0, 32'h0, 7'h4A, 1'b0, 3, 8'h01, 0, 8'h00, 0, 1, 1'b1, 1'b0);
        run_txn("r1_last_poll", 6'd55, 32'hDEADBEEF, 7'h11, 1'b1, NCR_MAX, 8'h05, 0, 8'h00, 0, 2, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            rd = ($urandom_range(0, 1) == 1);
            rv = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(0, 127));
            run_txn("random", 6'($urandom), $urandom, 7'($urandom), rd,
                    int'($urandom_range(0, NCR_MAX)), rv, int'($urandom_range(0, 20)),
                    ($urandom_range(0, 2) != 0) ? 8'hFE : 8'($urandom_range(0, 15)),
                    1, rd ? 0 : 2, 1'b0, 1'b0);
        end

        run_txn("reset_in_data", 6'd17, 32'h00001000, 7'h55, 1'b1, 1, 8'h00, 0, 8'hFE, 0, 0, 1'b0, 1'b1);
        run_txn("cmd0_after_reset", 6'd0, 32'h0, 7'h4A, 1'b0, 1, 8'h01, 0, 8'h00, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
